// File: rtl/mux_arb_nch_vector_if.sv
// Bus bundle for mux_arb_nch_vector.
// Carries the CH_NUM producer channels (data/valid/ready), the manual select override
// and the single registered output channel (data/valid/ready/sel).
//   master : producer/consumer side (drives in_*, manual_*, out_ready)
//   slave  : the mux itself (drives in_ready, out_data, out_valid, out_sel)
interface mux_arb_nch_vector_if #(
  parameter int unsigned VECTOR_LEN = 16,
  parameter int unsigned CH_NUM     = 8
);
  localparam int unsigned SEL_W = $clog2(CH_NUM);

  logic [CH_NUM*VECTOR_LEN-1:0] in_data;
  logic [CH_NUM-1:0]            in_valid;
  logic [CH_NUM-1:0]            in_ready;
  logic                         manual_en;
  logic [SEL_W-1:0]             manual_sel;
  logic [VECTOR_LEN-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_W-1:0]             out_sel;

  modport master (
    output in_data, in_valid, manual_en, manual_sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, manual_en, manual_sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_arbiter_nch.sv
// Combinational N-channel arbiter.
//   req   : per-channel request
//   ptr   : last served channel; search starts at ptr+1 and wraps (round-robin only)
//   grant : one-hot grant, or zero when nothing requests
// ARB_MODE=1 ignores ptr and gives the lowest requesting index priority.
module rr_arbiter_nch #(
  parameter int unsigned CH_NUM   = 8,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned SEL_W   = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [CH_NUM-1:0] grant
);

  logic [2*CH_NUM-1:0] req_dbl;
  logic [2*CH_NUM-1:0] window;
  logic [31:0]         start;
  logic                hit;

  always_comb begin
    // Fixed priority is round-robin with the pointer pinned to the top channel.
    start   = (ARB_MODE == 1) ? 32'(CH_NUM - 1) : 32'(ptr);
    req_dbl = {req, req};
    grant   = '0;
    hit     = 1'b0;
    // Positions start+1 .. start+CH_NUM of the doubled vector cover every channel once,
    // in search order, with ptr itself last.
    for (int unsigned i = 0; i < 2 * CH_NUM; i++) begin
      window[i] = (i > start) && (i <= start + CH_NUM);
    end
    for (int unsigned i = 0; i < 2 * CH_NUM; i++) begin
      if (!hit && req_dbl[i] && window[i]) begin
        hit                = 1'b1;
        grant[i % CH_NUM]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nch_vector.sv
// CH_NUM-to-1 vector mux with valid/ready on every channel and a single registered
// output stage (1 word/cycle, 1 cycle latency).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux_arb_nch_vector_if (inputs, manual override, output)
// Channel choice: manual_sel when manual_en, otherwise rr_arbiter_nch.
module mux_arb_nch_vector #(
  parameter int unsigned VECTOR_LEN = 16,
  parameter int unsigned CH_NUM     = 8,
  parameter int unsigned ARB_MODE   = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_arb_nch_vector_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(CH_NUM);

  logic [CH_NUM-1:0]     arb_grant;
  logic [CH_NUM-1:0]     grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [VECTOR_LEN-1:0] grant_data;
  logic                  load_en;
  logic                  xfer;

  logic [SEL_W-1:0]      rr_ptr_q;
  logic [SEL_W-1:0]      out_sel_q;
  logic [VECTOR_LEN-1:0] out_data_q;
  logic                  out_valid_q;

  rr_arbiter_nch #(
    .CH_NUM  (CH_NUM),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .req  (bus.in_valid),
    .ptr  (rr_ptr_q),
    .grant(arb_grant)
  );

  always_comb begin
    grant = '0;
    if (bus.manual_en) begin
      // Out-of-range selects (non power-of-two CH_NUM) grant nothing.
      if (int'(bus.manual_sel) < int'(CH_NUM)) begin
        grant[bus.manual_sel] = bus.in_valid[bus.manual_sel];
      end
    end else begin
      grant = arb_grant;
    end
  end

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_W'(i);
        grant_data = bus.in_data[i*VECTOR_LEN +: VECTOR_LEN];
      end
    end
  end

  // No handshake is offered while reset is held.
  assign load_en      = rst_n && (!out_valid_q || bus.out_ready);
  assign xfer         = load_en && (|grant);
  assign bus.in_ready = grant & {CH_NUM{load_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SEL_W'(CH_NUM - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_sel_q   <= grant_idx;
      if (!bus.manual_en && (ARB_MODE == 0)) begin
        rr_ptr_q <= grant_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/mux_arb_nch_vector.md
Name: mux_arb_nch_vector

Overview:
Parametrised successor to the team's fixed 8-to-1 vector mux. Selects one of CH_NUM VECTOR_LEN-wide input channels and forwards it through a single registered output stage. Every input and the output use valid/ready handshakes. Selection is by round-robin or fixed-priority arbitration, or by a manual select override. It sits between multiple producers (e.g. sample sources) and one shared consumer such as a FIFO, a UART TX path or a display driver.

Parameters:
VECTOR_LEN, 16, data width per channel (>=1)
CH_NUM, 8, number of input channels (>=2)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
SEL_W (localparam), $clog2(CH_NUM), width of channel index fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  CH_NUM*VECTOR_LEN  flattened channel data; channel i at [i*VECTOR_LEN +: VECTOR_LEN]
in_valid  in  CH_NUM  per-channel valid
in_ready  out  CH_NUM  per-channel ready (one-hot or zero)
manual_en  in  1  1 = bypass arbiter, use manual_sel
manual_sel  in  SEL_W  channel index when manual_en=1
out_data  out  VECTOR_LEN  registered selected data
out_valid  out  1  output register holds data
out_ready  in  1  consumer accepts out_data
out_sel  out  SEL_W  index of the channel currently held in out_data

Behaviour:
- Reset (async assert, sync deassert by the system): out_valid=0, out_data=0, out_sel=0, rr_ptr=CH_NUM-1, so the first round-robin search starts at channel 0.
- Output stage: one register.
  - load_en = !out_valid || out_ready (empty, or draining this cycle).
  - Throughput is 1 word/cycle. Latency is 1 cycle from input handshake to out_valid.
- Grant vector (combinational, one-hot or zero):
  - manual_en=1: grant channel manual_sel if in_valid[manual_sel]=1. No grant if that channel is not valid or if manual_sel >= CH_NUM.
  - manual_en=0, ARB_MODE=1: grant the lowest-index valid channel.
  - manual_en=0, ARB_MODE=0: grant the first valid channel searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo CH_NUM. rr_ptr itself is searched last.
- Handshakes:
  - in_ready = grant & {CH_NUM{load_en}}.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - in_ready never depends on in_data. Upstream must hold valid and data until ready.
- On a transfer: out_data <= channel data, out_sel <= i, out_valid <= 1.
  - In round-robin mode only, rr_ptr <= i.
  - rr_ptr is unchanged on manual transfers and in fixed-priority mode.
- Output drain with no transfer (out_valid && out_ready and no grant): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold, and all in_ready=0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1, with no bubble.
- Changing manual_en or manual_sel mid-stream takes effect on the next grant evaluation. A word already in the output register is unaffected.
- Asserting reset mid-transfer discards the held word immediately.

Decomposition:
- No shared package is needed. SEL_W is a localparam.
- One natural sub-module, rr_arbiter_nch (params CH_NUM, ARB_MODE): req[CH_NUM], ptr[SEL_W], grant[CH_NUM]. It is purely combinational, implemented as a double-width request mask with a priority encode.
- The top level holds the data mux, output register, handshake logic and rr_ptr.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. After release, the first grant goes to channel 0 (rr_ptr=7).
- Round-robin fairness: CH_NUM=8, all in_valid=1, in_data[i]=16'h1000+i, out_ready=1 -> out_sel sequence 0,1,...,7,0, one word per cycle, no bubbles.
- Sparse round-robin: valid only on channels 2 and 5 -> alternating out_sel 2,5,2,5. Dropping ch5 valid leaves ch2 served every cycle.
- Fixed priority (ARB_MODE=1): channels 1, 3 and 6 valid -> out_sel=1 every cycle. Deasserting ch1 valid moves service to 3.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data and out_sel stable, in_ready=0. Raising out_ready transfers the next word in the same cycle.
- Manual override: manual_en=1, manual_sel=4, ch4 data 16'hBEEF -> out_data=16'hBEEF and out_sel=4, and rr_ptr is unchanged afterward. With manual_sel=4 and ch4 not valid -> no transfer, and out_valid falls after a drain.
